// File: rtl/multicycle_control.sv
// Multicycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a latched
// control word, branch resolution from ALU flags, IO/RAM address classification and trap capture.
module multicycle_control #(
  parameter logic [31:0] IO_BASE   = 32'hFFFFFC00,
  parameter logic [31:0] RAM_LIMIT = 32'h00010000,
  parameter int          MEM_WAIT  = 1,
  parameter int          ALUOP_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instruction,
  input  logic               inst_ready,
  input  logic [31:0]        alu_result,
  input  logic               alu_zero,
  input  logic               alu_lt,
  input  logic               alu_ltu,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               ALUSrc,
  output logic               sftmd,
  output logic               RegWrite,
  output logic               MemorIOToReg,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IORead,
  output logic               IOWrite,
  output logic [2:0]         state,
  output logic               trap,
  output logic [1:0]         trap_cause
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    K_ALU = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2, K_BRANCH = 3'd3, K_JAL = 3'd4, K_JALR = 3'd5
  } kind_t;

  typedef struct packed {
    kind_t              kind;
    logic [ALUOP_W-1:0] aluop;
    logic               alusrc;
    logic               sftmd;
    logic [2:0]         br_f3;
  } ctrl_t;

  state_t     state_q, state_d;
  ctrl_t      cw, dec;
  logic       illegal;
  logic [3:0] cnt;
  logic       mem_first, mem_io;
  logic       trap_q;
  logic [1:0] cause_q;
  logic       taken, io_hit, ram_hit, mem_io_now, mem_ok;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  logic       unused_fields;

  assign opcode        = instruction[6:0];
  assign f3            = instruction[14:12];
  assign f7            = instruction[31:25];
  assign unused_fields = ^{instruction[24:15], instruction[11:7]};

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'd0: dec.aluop = ALUOP_W'(0);
            3'd1: begin dec.aluop = ALUOP_W'(5); dec.sftmd = 1'b1; end
            3'd2: dec.aluop = ALUOP_W'(10);
            3'd3: dec.aluop = ALUOP_W'(11);
            3'd4: dec.aluop = ALUOP_W'(2);
            3'd5: begin dec.aluop = ALUOP_W'(6); dec.sftmd = 1'b1; end
            3'd6: dec.aluop = ALUOP_W'(3);
            default: dec.aluop = ALUOP_W'(4);
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'd0) begin
          dec.aluop = ALUOP_W'(1);
        end else if (f7 == 7'b0100000 && f3 == 3'd5) begin
          dec.aluop = ALUOP_W'(7);
          dec.sftmd = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      7'b0010011: begin
        dec.alusrc = 1'b1;
        case (f3)
          3'd0: dec.aluop = ALUOP_W'(0);
          3'd2: dec.aluop = ALUOP_W'(10);
          3'd3: dec.aluop = ALUOP_W'(11);
          3'd4: dec.aluop = ALUOP_W'(2);
          3'd6: dec.aluop = ALUOP_W'(3);
          3'd7: dec.aluop = ALUOP_W'(4);
          default: begin
            // Shift-immediates: funct7 carries only the arithmetic/logical select.
            dec.sftmd = 1'b1;
            if (f7 != 7'b0000000 && f7 != 7'b0100000) illegal = 1'b1;
            if (f3 == 3'd1)  dec.aluop = ALUOP_W'(5);
            else if (f7[5])  dec.aluop = ALUOP_W'(7);
            else             dec.aluop = ALUOP_W'(6);
          end
        endcase
      end
      7'b0000011: begin dec.kind = K_LOAD;  dec.alusrc = 1'b1; end
      7'b0100011: begin dec.kind = K_STORE; dec.alusrc = 1'b1; end
      7'b1100011: begin
        dec.kind  = K_BRANCH;
        dec.aluop = ALUOP_W'(1);
        dec.br_f3 = f3;
        if (f3 == 3'd2 || f3 == 3'd3) illegal = 1'b1;
      end
      7'b1101111: begin dec.kind = K_JAL; dec.alusrc = 1'b1; end
      7'b1100111: begin
        dec.kind   = K_JALR;
        dec.alusrc = 1'b1;
        if (f3 != 3'd0) illegal = 1'b1;
      end
      7'b0110111: begin dec.aluop = ALUOP_W'(8); dec.alusrc = 1'b1; end
      7'b0010111: begin dec.aluop = ALUOP_W'(9); dec.alusrc = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (cw.br_f3)
      3'b000: taken = alu_zero;
      3'b001: taken = !alu_zero;
      3'b100: taken = alu_lt;
      3'b101: taken = !alu_lt;
      3'b110: taken = alu_ltu;
      3'b111: taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  // The window is classified once on MEM entry and held for the remaining wait cycles.
  assign io_hit     = (alu_result >= IO_BASE);
  assign ram_hit    = (alu_result < RAM_LIMIT);
  assign mem_io_now = mem_first ? io_hit : mem_io;
  assign mem_ok     = mem_first ? (io_hit || ram_hit) : 1'b1;

  always_comb begin
    state_d      = state_q;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    ALUop        = '0;
    ALUSrc       = 1'b0;
    sftmd        = 1'b0;
    RegWrite     = 1'b0;
    MemorIOToReg = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IORead       = 1'b0;
    IOWrite      = 1'b0;
    state        = 3'd0;
    trap         = 1'b0;
    trap_cause   = 2'd0;
    if (!rst) begin
      state      = state_q;
      trap       = trap_q;
      trap_cause = cause_q;
      case (state_q)
        S_FETCH: begin
          ir_write = inst_ready;
          if (inst_ready) state_d = S_DECODE;
        end
        S_DECODE: state_d = illegal ? S_TRAP : S_EXEC;
        S_EXEC: begin
          ALUop  = cw.aluop;
          ALUSrc = cw.alusrc;
          sftmd  = cw.sftmd;
          case (cw.kind)
            K_BRANCH: begin
              pc_write = 1'b1;
              pc_src   = taken ? 2'd1 : 2'd0;
              state_d  = S_FETCH;
            end
            K_LOAD, K_STORE: state_d = S_MEM;
            default:         state_d = S_WB;
          endcase
        end
        S_MEM: begin
          if (!mem_ok) begin
            state_d = S_TRAP;
          end else begin
            if (cw.kind == K_LOAD) begin
              IORead  = mem_io_now;
              MemRead = !mem_io_now;
            end else begin
              IOWrite  = mem_io_now;
              MemWrite = !mem_io_now;
            end
            if (cnt == 4'd0) begin
              if (cw.kind == K_STORE) begin
                pc_write = 1'b1;
                state_d  = S_FETCH;
              end else begin
                state_d = S_WB;
              end
            end
          end
        end
        S_WB: begin
          RegWrite     = 1'b1;
          MemorIOToReg = (cw.kind == K_LOAD);
          pc_write     = 1'b1;
          pc_src       = (cw.kind == K_JAL) ? 2'd1 : (cw.kind == K_JALR) ? 2'd2 : 2'd0;
          state_d      = S_FETCH;
        end
        S_TRAP: state_d = S_TRAP;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cw        <= '0;
      cnt       <= 4'd0;
      mem_first <= 1'b0;
      mem_io    <= 1'b0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && state_d == S_EXEC) cw <= dec;
      if (state_q == S_EXEC && state_d == S_MEM) begin
        cnt       <= 4'(MEM_WAIT - 1);
        mem_first <= 1'b1;
      end else if (state_q == S_MEM) begin
        mem_first <= 1'b0;
        if (mem_first) mem_io <= io_hit;
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
      end
      if (state_d == S_TRAP && state_q != S_TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= (state_q == S_DECODE) ? 2'd1 : 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: vector table, hand-built corner sequences and
// random instructions checked against a cycle-trace model built from the instruction rules.
module tb_multicycle_control;
  localparam int          MW    = 3;
  localparam logic [31:0] IO_B  = 32'hFFFFFC00;
  localparam logic [31:0] RAM_L = 32'h00010000;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
    OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
    OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, inst_ready = 1'b1, alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
  logic [31:0] instruction = 32'h0, alu_result = 32'h0;
  logic        ir_write, pc_write, ALUSrc, sftmd, RegWrite, MemorIOToReg;
  logic        MemRead, MemWrite, IORead, IOWrite, trap;
  logic [1:0]  pc_src, trap_cause;
  logic [3:0]  ALUop;
  logic [2:0]  state;

  multicycle_control #(.IO_BASE(IO_B), .RAM_LIMIT(RAM_L), .MEM_WAIT(MW), .ALUOP_W(4)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .inst_ready(inst_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .ALUop(ALUop),
    .ALUSrc(ALUSrc), .sftmd(sftmd), .RegWrite(RegWrite), .MemorIOToReg(MemorIOToReg),
    .MemRead(MemRead), .MemWrite(MemWrite), .IORead(IORead), .IOWrite(IOWrite),
    .state(state), .trap(trap), .trap_cause(trap_cause)
  );

  typedef struct packed {
    logic [2:0] st; logic irw; logic pcw; logic [1:0] pcs; logic [3:0] aop; logic asrc;
    logic sft; logic rw; logic m2r; logic mr; logic mw; logic ior; logic iow; logic tr;
    logic [1:0] tc;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  logic [OBS_W-1:0] exp_q[$];
  int n_cmp = 0, n_fail = 0;

  function automatic obs_t observe();
    obs_t o;
    o = '{st: state, irw: ir_write, pcw: pc_write, pcs: pc_src, aop: ALUop, asrc: ALUSrc,
          sft: sftmd, rw: RegWrite, m2r: MemorIOToReg, mr: MemRead, mw: MemWrite,
          ior: IORead, iow: IOWrite, tr: trap, tc: trap_cause};
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction

  // ---------------- reference model ----------------
  localparam logic [3:0] R_TAB [16] = '{4'd0, 4'd5, 4'd10, 4'd11, 4'd2, 4'd6, 4'd3, 4'd4,
                                        4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 4'd0};

  // kind: 0 alu, 1 load, 2 store, 3 branch, 4 jal, 5 jalr
  function automatic void ref_decode(input logic [31:0] ins, output bit legal, output int kind,
                                     output logic [3:0] aop, output logic asrc, output logic sft);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    legal = 1'b1; kind = 0; aop = 4'd0; asrc = 1'b0; sft = 1'b0;
    if (op == OP_R) begin
      sft = (f3 == 3'd1 || f3 == 3'd5);
      if (f7 == 7'h00) aop = R_TAB[{1'b0, f3}];
      else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) aop = R_TAB[{1'b1, f3}];
      else legal = 1'b0;
    end else if (op == OP_I) begin
      asrc = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        sft = 1'b1;
        legal = (f7 == 7'h00 || f7 == 7'h20);
        aop = R_TAB[{(f3 == 3'd5) && f7[5], f3}];
      end else aop = R_TAB[{1'b0, f3}];
    end else if (op == OP_LD) begin kind = 1; asrc = 1'b1; end
    else if (op == OP_ST) begin kind = 2; asrc = 1'b1; end
    else if (op == OP_BR) begin kind = 3; aop = 4'd1; legal = (f3 != 3'd2 && f3 != 3'd3); end
    else if (op == OP_JAL) begin kind = 4; asrc = 1'b1; end
    else if (op == OP_JALR) begin kind = 5; asrc = 1'b1; legal = (f3 == 3'd0); end
    else if (op == OP_LUI) begin aop = 4'd8; asrc = 1'b1; end
    else if (op == OP_AUIPC) begin aop = 4'd9; asrc = 1'b1; end
    else legal = 1'b0;
  endfunction

  function automatic void push_trap(input logic [1:0] cause);
    obs_t o;
    o = '0; o.st = 3'd7; o.tr = 1'b1; o.tc = cause;
    exp_q.push_back(o); exp_q.push_back(o);
  endfunction

  // Expected per-cycle outputs for one instruction starting in FETCH with inst_ready=1.
  function automatic void build_trace(input logic [31:0] ins, input logic z, input logic lt,
                                      input logic ltu, input logic [31:0] addr, output bit trapped);
    obs_t o; bit legal; int kind; logic [3:0] aop; logic asrc, sft, tk; int region;
    trapped = 1'b0;
    ref_decode(ins, legal, kind, aop, asrc, sft);
    o = '0; o.irw = 1'b1; exp_q.push_back(o);
    o = '0; o.st = 3'd1; exp_q.push_back(o);
    if (!legal) begin push_trap(2'd1); trapped = 1'b1; return; end
    o = '0; o.st = 3'd2; o.aop = aop; o.asrc = asrc; o.sft = sft;
    if (kind == 3) begin
      case (ins[14:12])
        3'd0: tk = z;   3'd1: tk = !z;
        3'd4: tk = lt;  3'd5: tk = !lt;
        3'd6: tk = ltu; default: tk = !ltu;
      endcase
      o.pcw = 1'b1; o.pcs = {1'b0, tk};
      exp_q.push_back(o);
      return;
    end
    exp_q.push_back(o);
    if (kind == 1 || kind == 2) begin
      region = (addr >= IO_B) ? 1 : (addr < RAM_L) ? 2 : 0;
      if (region == 0) begin
        o = '0; o.st = 3'd3; exp_q.push_back(o);
        push_trap(2'd2); trapped = 1'b1; return;
      end
      for (int i = 0; i < MW; i++) begin
        o = '0; o.st = 3'd3;
        if (kind == 1) begin o.ior = (region == 1); o.mr = (region == 2); end
        else begin o.iow = (region == 1); o.mw = (region == 2); o.pcw = (i == MW - 1); end
        exp_q.push_back(o);
      end
      if (kind == 2) return;
    end
    o = '0; o.st = 3'd4; o.rw = 1'b1; o.m2r = (kind == 1); o.pcw = 1'b1;
    o.pcs = (kind == 4) ? 2'd1 : (kind == 5) ? 2'd2 : 2'd0;
    exp_q.push_back(o);
  endfunction

  // ---------------- driver tasks (entry/exit at a falling edge) ----------------
  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1 check("reset_outputs", observe(), '0);
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

  task automatic drive(input logic [31:0] ins, input logic z, input logic lt, input logic ltu,
                       input logic [31:0] addr);
    instruction = ins; alu_zero = z; alu_lt = lt; alu_ltu = ltu; alu_result = addr;
    inst_ready = 1'b1;
  endtask

  task automatic run_model(input string tag, input logic [31:0] ins, input logic z,
                           input logic lt, input logic ltu, input logic [31:0] addr,
                           output bit trapped);
    int cyc;
    logic [OBS_W-1:0] want;
    drive(ins, z, lt, ltu, addr);
    build_trace(ins, z, lt, ltu, addr, trapped);
    cyc = 0;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      #1 check($sformatf("%s ins=%h cyc%0d", tag, ins, cyc), observe(), want);
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    logic [31:0] ins; logic z, lt, ltu; logic [31:0] addr;
    int cyc; logic [3:0] aop; logic [3:0] smask; int scyc; int rw; int pcw;
    logic [1:0] pcs; logic [1:0] cause;
  } vec_t;

  vec_t vecs[21];

  task automatic run_vec(input int idx, input vec_t v);
    obs_t o; int cyc, scyc, rw, pcw; logic [3:0] aop, smask; logic [1:0] pcs, cause;
    bit done;
    drive(v.ins, v.z, v.lt, v.ltu, v.addr);
    cyc = 0; scyc = 0; rw = 0; pcw = 0; aop = 4'd0; smask = 4'd0; pcs = 2'd0; cause = 2'd0;
    done = 1'b0;
    while (!done) begin
      #1 o = observe();
      if (cyc > 0 && (o.st == 3'd0 || o.st == 3'd7)) begin
        cause = o.tc;
        done = 1'b1;
      end else begin
        if (o.st == 3'd2) aop = o.aop;
        if (o.mr | o.mw | o.ior | o.iow) scyc++;
        smask = smask | {o.mr, o.mw, o.ior, o.iow};
        if (o.rw) rw++;
        if (o.pcw) begin pcw++; pcs = o.pcs; end
        cyc++;
        if (cyc > 40) begin
          check($sformatf("v%0d timeout", idx), 64'(cyc), 64'(v.cyc));
          done = 1'b1;
        end else @(negedge clk);
      end
    end
    check($sformatf("v%0d cycles", idx), 64'(cyc), 64'(v.cyc));
    check($sformatf("v%0d aluop", idx), 64'(aop), 64'(v.aop));
    check($sformatf("v%0d strobes", idx), 64'(smask), 64'(v.smask));
    check($sformatf("v%0d strobe_cycles", idx), 64'(scyc), 64'(v.scyc));
    check($sformatf("v%0d regwrite", idx), 64'(rw), 64'(v.rw));
    check($sformatf("v%0d pc_write", idx), 64'(pcw), 64'(v.pcw));
    check($sformatf("v%0d pc_src", idx), 64'(pcs), 64'(v.pcs));
    check($sformatf("v%0d cause", idx), 64'(cause), 64'(v.cause));
    if (v.cause != 2'd0 || cyc > 40) do_reset(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit trapped;
    logic [31:0] ins, addr;
    logic [6:0] ops [10];
    vecs[0]  = '{mk(7'h00, 3'd0, OP_R), 0, 0, 0, 32'h0, 4, 4'd0, 4'b0000, 0, 1, 1, 2'd0, 2'd0};
    vecs[1]  = '{mk(7'h20, 3'd0, OP_R), 0, 0, 0, 32'h0, 4, 4'd1, 4'b0000, 0, 1, 1, 2'd0, 2'd0};
    vecs[2]  = '{mk(7'h20, 3'd5, OP_R), 0, 0, 0, 32'h0, 4, 4'd7, 4'b0000, 0, 1, 1, 2'd0, 2'd0};
    vecs[3]  = '{mk(7'h00, 3'd3, OP_R), 0, 0, 0, 32'h0, 4, 4'd11, 4'b0000, 0, 1, 1, 2'd0, 2'd0};
    vecs[4]  = '{mk(7'h20, 3'd5, OP_I), 0, 0, 0, 32'h0, 4, 4'd7, 4'b0000, 0, 1, 1, 2'd0, 2'd0};
    vecs[5]  = '{mk(7'h55, 3'd3, OP_I), 0, 0, 0, 32'h0, 4, 4'd11, 4'b0000, 0, 1, 1, 2'd0, 2'd0};
    vecs[6]  = '{mk(7'h00, 3'd2, OP_LD), 0, 0, 0, 32'h00000100, 7, 4'd0, 4'b1000, 3, 1, 1, 2'd0, 2'd0};
    vecs[7]  = '{mk(7'h00, 3'd0, OP_LD), 0, 0, 0, 32'hFFFFFC00, 7, 4'd0, 4'b0010, 3, 1, 1, 2'd0, 2'd0};
    vecs[8]  = '{mk(7'h00, 3'd2, OP_ST), 0, 0, 0, 32'hFFFFFC60, 6, 4'd0, 4'b0001, 3, 0, 1, 2'd0, 2'd0};
    vecs[9]  = '{mk(7'h00, 3'd2, OP_ST), 0, 0, 0, 32'hFFFFFBFC, 4, 4'd0, 4'b0000, 0, 0, 0, 2'd0, 2'd2};
    vecs[10] = '{mk(7'h00, 3'd6, OP_BR), 0, 0, 1, 32'h0, 3, 4'd1, 4'b0000, 0, 0, 1, 2'd1, 2'd0};
    vecs[11] = '{mk(7'h00, 3'd6, OP_BR), 0, 0, 0, 32'h0, 3, 4'd1, 4'b0000, 0, 0, 1, 2'd0, 2'd0};
    vecs[12] = '{mk(7'h00, 3'd5, OP_BR), 0, 0, 0, 32'h0, 3, 4'd1, 4'b0000, 0, 0, 1, 2'd1, 2'd0};
    vecs[13] = '{mk(7'h00, 3'd0, OP_JAL), 0, 0, 0, 32'h0, 4, 4'd0, 4'b0000, 0, 1, 1, 2'd1, 2'd0};
    vecs[14] = '{mk(7'h00, 3'd0, OP_JALR), 0, 0, 0, 32'h0, 4, 4'd0, 4'b0000, 0, 1, 1, 2'd2, 2'd0};
    vecs[15] = '{mk(7'h12, 3'd4, OP_LUI), 0, 0, 0, 32'h0, 4, 4'd8, 4'b0000, 0, 1, 1, 2'd0, 2'd0};
    vecs[16] = '{mk(7'h34, 3'd1, OP_AUIPC), 0, 0, 0, 32'h0, 4, 4'd9, 4'b0000, 0, 1, 1, 2'd0, 2'd0};
    vecs[17] = '{32'h0000007F, 0, 0, 0, 32'h0, 2, 4'd0, 4'b0000, 0, 0, 0, 2'd0, 2'd1};
    vecs[18] = '{mk(7'h01, 3'd1, OP_I), 0, 0, 0, 32'h0, 2, 4'd0, 4'b0000, 0, 0, 0, 2'd0, 2'd1};
    vecs[19] = '{mk(7'h00, 3'd2, OP_LD), 0, 0, 0, 32'h00010000, 4, 4'd0, 4'b0000, 0, 0, 0, 2'd0, 2'd2};
    vecs[20] = '{mk(7'h00, 3'd2, OP_BR), 1, 0, 0, 32'h0, 2, 4'd0, 4'b0000, 0, 0, 0, 2'd0, 2'd1};
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'h00};

    @(negedge clk);
    do_reset(2);
    #1 check("post_reset_state", 64'(state), 64'd0);

    // add x3,x1,x2 traced cycle by cycle: 0,1,2,4 then back to 0
    run_model("add_trace", 32'h002081B3, 0, 0, 0, 32'h0, trapped);
    #1 check("add_back_to_fetch", 64'(state), 64'd0);

    // instruction memory not ready: FETCH holds without loading IR
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check($sformatf("stall%0d", i), 64'({state, ir_write}), 64'd0);
      @(negedge clk);
    end
    inst_ready = 1'b1;

    for (int i = 0; i < 21; i++) run_vec(i, vecs[i]);

    // illegal opcode: TRAP is sticky until reset
    run_model("illegal", 32'h0000007F, 0, 0, 0, 32'h0, trapped);
    for (int i = 0; i < 20; i++) begin
      #1 check($sformatf("trap_hold%0d", i), 64'({state, trap, trap_cause, pc_write}),
               64'({3'd7, 1'b1, 2'd1, 1'b0}));
      @(negedge clk);
    end
    do_reset(1);
    #1 check("trap_cleared", 64'({state, trap, trap_cause}), 64'd0);

    // reset during the second MEM cycle of a RAM load
    drive(mk(7'h00, 3'd2, OP_LD), 0, 0, 0, 32'h00000100);
    repeat (4) @(negedge clk);
    #1 check("mem2_memread", 64'({state, MemRead}), 64'({3'd3, 1'b1}));
    rst = 1'b1;
    #1 check("mem2_rst_strobe", 64'({MemRead, IORead, pc_write}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("mem2_rst_fetch", 64'({state, MemRead}), 64'd0);

    // randomized instructions against the trace model
    for (int n = 0; n < 150; n++) begin
      ins = $urandom();
      ins[6:0] = ops[$urandom_range(0, 9)];
      if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom());
      case ($urandom_range(0, 2))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0: addr = $urandom_range(0, int'(RAM_L) - 1);
        1: addr = IO_B + 32'($urandom_range(0, 1023));
        2: addr = RAM_L + ($urandom() % (IO_B - RAM_L));
        3: addr = RAM_L - 32'd1;
        4: addr = RAM_L;
        5: addr = IO_B - 32'd1;
        6: addr = IO_B;
        default: addr = 32'hFFFFFFFF;
      endcase
      run_model("rand", ins, 1'($urandom()), 1'($urandom()), 1'($urandom()), addr, trapped);
      if (trapped) do_reset(1);
    end
    #1 check("final_fetch", 64'(state), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
